box_overlay: RTL
================

// Module: box_overlay
// PURPOSE
//  Multi-box overlay stage on the 49-bit HDMI pixel pack. Generalises single-frame box drawing with:
//  - runtime-written, frame-synchronous box registers;
//  - per-box mode (outline / filled / 50% blend);
//  - parametrised border thickness;
//  - an explicit valid bit per box.
//  Sits in the video path after detection and before HDMI output, between hdmi_unpack and hdmi_pack.
// PARAMETERS
//  N_BOX     4      number of boxes; higher index wins on overlap
//  H_BORDER  2      outline thickness in pixels, horizontal (>=1)
//  V_BORDER  2      outline thickness in lines, vertical (>=1)
//  H_ACT     1280   active width; X_W = $clog2(H_ACT)
//  V_ACT     720    active height; Y_W = $clog2(V_ACT)
//  VS_POL    1'b1   vsync active level
// PORTS
//  clk             in   1         pixel clock; same clock as the one carried in i_pack
//  rstn            in   1         asynchronous reset, active-low
//  en              in   1         0: pixels pass through unmodified; latency unchanged
//  i_pack          in   49        input pixel pack
//  o_pack          out  49        output pixel pack
//  cfg_we          in   1         write shadow entry cfg_idx
//  cfg_idx         in   IDX_W     box index; IDX_W = max(1, $clog2(N_BOX))
//  cfg_sx/cfg_ex   in   X_W       box start/end x, inclusive
//  cfg_sy/cfg_ey   in   Y_W       box start/end y, inclusive
//  cfg_color       in   24        {r,g,b}
//  cfg_mode        in   2         0 off, 1 outline, 2 filled, 3 blend
//  cfg_commit      in   1         request shadow->active copy at next frame start
//  commit_pending  out  1         high from the cycle after cfg_commit until the copy
// BEHAVIOUR
//  Reset: all shadow and active entries cleared (mode=off). commit_pending=0.
//   Pipeline registers are 0, so o_pack fields are hsync/vsync/de/rgb/x/y = 0.
//  Config writes:
//   - cfg_we writes shadow[cfg_idx] in one cycle, at any time.
//   - cfg_idx >= N_BOX is ignored.
//   - Shadow contents never affect pixels directly.
//  Frame start:
//   - Defined as registered vsync != VS_POL && current vsync == VS_POL.
//   - If pending=1, active <= shadow for all boxes and pending clears on that edge.
//   - A cfg_we on the frame-start cycle is applied to shadow only and is not copied this frame.
//   - A cfg_commit on the frame-start cycle sets pending; the copy happens at the following frame start.
//   - A repeated cfg_commit while pending is a no-op.
//  Hit test, per box, on unpacked x,y:
//   - Box is ignored if mode=off, sx>ex or sy>ey.
//   - in_outer = sx<=x<=ex && sy<=y<=ey.
//   - in_inner is computed in X_W+1 / Y_W+1 bits (no wrap):
//     sx+H_BORDER<=x<=ex-H_BORDER && sy+V_BORDER<=y<=ey-V_BORDER.
//     If ex < sx+2*H_BORDER, or the y equivalent, in_inner=0 (entire box is border).
//   - Outline hit = in_outer && !in_inner. Filled/blend hit = in_outer.
//  Colour select: the highest-index hit box wins.
//   - Outline/filled: out = color.
//   - Blend, per channel: out = (pix>>1)+(col>>1), 8 bits, truncating; max 254, no overflow.
//   - No hit or en=0: out = pixel.
//  Pipeline and latency:
//   - Stage 1 registers per-box hit vector, winner index, pixel and sync/de/x/y.
//   - Stage 2 registers the blended rgb and the delayed sync/de/x/y.
//   - Latency is exactly 2 clk for every pack field. de/hsync/vsync/x/y are unmodified.
//  Active-box changes take effect on the first pixel after frame start.
//   - Pixels already in the pipeline use the box values they sampled in stage 1.
//  Async reset mid-frame: outputs zero immediately. Pending commit is lost. Boxes return to off.
// STRUCTURE
//  - Package draw_pkg:
//    - box_mode_e enum (OFF, OUTLINE, FILLED, BLEND);
//    - box_cfg_t struct {sx, sy, ex, ey, color, mode};
//    - helper function blend50().
//  - Sub-module box_hit, combinational, instantiated N_BOX times: cfg + x,y -> hit.
//  - hdmi_unpack / hdmi_pack reused at the edges.
//  - Shadow/active arrays, commit FSM (IDLE/PENDING) and the two pipeline stages live in box_overlay.
// TESTING
//  1. Reset then stream a frame -> o_pack equals i_pack delayed 2 clk; commit_pending=0.
//  2. Box 0 outline (100,50)-(199,149), red, commit, then frame start:
//     - (100,50), (101,51), (199,149) -> ff0000;
//     - (102,52), (99,50) -> unchanged.
//  3. Blend box, color 0xff_ff_ff over pixel 0x20_40_60 -> output 0x8f_9f_af.
//  4. Boxes 0 and 1 overlap at (150,100), both filled, green/blue -> output blue (box 1 wins).
//  5. Commit mid-frame:
//     - pixels keep the old boxes until the next frame start;
//     - commit_pending stays 1 until the vsync edge, then 0;
//     - commit on the frame-start cycle defers one frame.
//  6. Box (10,10)-(12,12), H/V_BORDER=2 -> all 9 pixels drawn.
//     Box sx=20>ex=10 -> nothing drawn.
//     en=0 with box active -> passthrough.
//     rstn low mid-frame -> o_pack zero and boxes cleared.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types for the box overlay: box modes, commit FSM states,
// per-box configuration record and the 50% blend helper.
package draw_pkg;

    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        OUTLINE = 2'd1,
        FILLED  = 2'd2,
        BLEND   = 2'd3
    } box_mode_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } commit_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [COORD_W-1:0] ex;
        logic [COORD_W-1:0] ey;
        logic [23:0]        color;
        box_mode_e          mode;
    } box_cfg_t;

    // Per channel (pix>>1)+(col>>1); peaks at 254 so 8 bits never overflow.
    function automatic logic [23:0] blend50(input logic [23:0] pix, input logic [23:0] col);
        logic [23:0] r;
        r = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            r[c*8 +: 8] = {1'b0, pix[c*8+1 +: 7]} + {1'b0, col[c*8+1 +: 7]};
        end
        return r;
    endfunction

endpackage

// File: rtl/box_hit.sv
// Combinational hit test of one box against a pixel coordinate.
// Inner-region math is one bit wider than the coordinates so nothing wraps.
module box_hit
    import draw_pkg::*;
#(
    parameter int unsigned X_W      = 11,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned H_BORDER = 2,
    parameter int unsigned V_BORDER = 2
) (
    input  box_cfg_t         i_cfg,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    output logic             o_hit
);

    localparam int unsigned CW = COORD_W + 1;

    logic [CW-1:0] w_x, w_y, w_sx, w_sy, w_ex, w_ey;
    logic [CW-1:0] w_hb, w_vb, w_hb2, w_vb2;
    logic          w_valid, w_in_outer, w_inner_ok, w_in_inner;

    assign w_x   = CW'(i_x);
    assign w_y   = CW'(i_y);
    assign w_sx  = CW'(i_cfg.sx);
    assign w_sy  = CW'(i_cfg.sy);
    assign w_ex  = CW'(i_cfg.ex);
    assign w_ey  = CW'(i_cfg.ey);
    assign w_hb  = CW'(H_BORDER);
    assign w_vb  = CW'(V_BORDER);
    assign w_hb2 = CW'(2 * H_BORDER);
    assign w_vb2 = CW'(2 * V_BORDER);

    assign w_valid    = (i_cfg.mode != OFF) && (w_sx <= w_ex) && (w_sy <= w_ey);
    assign w_in_outer = (w_sx <= w_x) && (w_x <= w_ex) && (w_sy <= w_y) && (w_y <= w_ey);

    // Boxes too small to have an interior are drawn entirely as border.
    assign w_inner_ok = (w_ex >= w_sx + w_hb2) && (w_ey >= w_sy + w_vb2);
    assign w_in_inner = w_inner_ok
                     && (w_sx + w_hb <= w_x) && (w_x + w_hb <= w_ex)
                     && (w_sy + w_vb <= w_y) && (w_y + w_vb <= w_ey);

    assign o_hit = w_valid && w_in_outer && ((i_cfg.mode != OUTLINE) || !w_in_inner);

endmodule

// File: rtl/box_overlay.sv
// Multi-box overlay on the pixel pack {clk, hsync, vsync, de, r, g, b, x, y} (MSB first).
// Shadow registers are copied to the active set at the frame start following a commit.
module box_overlay
    import draw_pkg::*;
#(
    parameter int unsigned N_BOX    = 4,
    parameter int unsigned H_BORDER = 2,
    parameter int unsigned V_BORDER = 2,
    parameter int unsigned H_ACT    = 1280,
    parameter int unsigned V_ACT    = 720,
    parameter logic        VS_POL   = 1'b1,
    localparam int unsigned X_W     = $clog2(H_ACT),
    localparam int unsigned Y_W     = $clog2(V_ACT),
    localparam int unsigned IDX_W   = (N_BOX > 1) ? $clog2(N_BOX) : 1,
    localparam int unsigned PACK_W  = 28 + X_W + Y_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [PACK_W-1:0] i_pack,
    output logic [PACK_W-1:0] o_pack,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [X_W-1:0]    cfg_sx,
    input  logic [X_W-1:0]    cfg_ex,
    input  logic [Y_W-1:0]    cfg_sy,
    input  logic [Y_W-1:0]    cfg_ey,
    input  logic [23:0]       cfg_color,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_commit,
    output logic              commit_pending
);

    localparam int unsigned X_LSB   = Y_W;
    localparam int unsigned RGB_LSB = X_W + Y_W;
    localparam int unsigned VS_BIT  = RGB_LSB + 25;

    box_cfg_t          r_shadow [N_BOX];
    box_cfg_t          r_active [N_BOX];
    commit_state_e     r_state;
    logic              r_pending;
    logic              r_vs_prev;

    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;
    logic              w_vs, w_frame_start;
    logic [N_BOX-1:0]  w_hit;
    logic [23:0]       w_win_color;
    logic              w_win_blend;

    logic [PACK_W-1:0] r_s1_pack, r_s2_pack;
    logic [N_BOX-1:0]  r_s1_hit;
    logic [23:0]       r_s1_color;
    logic              r_s1_blend;

    assign w_x           = i_pack[X_LSB +: X_W];
    assign w_y           = i_pack[0 +: Y_W];
    assign w_vs          = i_pack[VS_BIT];
    assign w_frame_start = (r_vs_prev != VS_POL) && (w_vs == VS_POL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < N_BOX; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_prev <= w_vs;
            if (cfg_we && (32'(cfg_idx) < N_BOX)) begin
                r_shadow[cfg_idx] <= '{sx: COORD_W'(cfg_sx), sy: COORD_W'(cfg_sy),
                                       ex: COORD_W'(cfg_ex), ey: COORD_W'(cfg_ey),
                                       color: cfg_color, mode: box_mode_e'(cfg_mode)};
            end
            case (r_state)
                IDLE: begin
                    if (cfg_commit) begin
                        r_state   <= PENDING;
                        r_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    // A commit arriving on the copy cycle re-arms for the next frame.
                    if (w_frame_start) begin
                        for (int unsigned i = 0; i < N_BOX; i++) begin
                            r_active[i] <= r_shadow[i];
                        end
                        if (!cfg_commit) begin
                            r_state   <= IDLE;
                            r_pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_pending <= 1'b0;
                end
            endcase
        end
    end

    assign commit_pending = r_pending;

    for (genvar g = 0; g < N_BOX; g++) begin : g_hit
        box_hit #(
            .X_W      (X_W),
            .Y_W      (Y_W),
            .H_BORDER (H_BORDER),
            .V_BORDER (V_BORDER)
        ) u_box_hit (
            .i_cfg (r_active[g]),
            .i_x   (w_x),
            .i_y   (w_y),
            .o_hit (w_hit[g])
        );
    end

    always_comb begin
        w_win_color = '0;
        w_win_blend = 1'b0;
        for (int unsigned i = 0; i < N_BOX; i++) begin
            if (w_hit[i]) begin
                w_win_color = r_active[i].color;
                w_win_blend = (r_active[i].mode == BLEND);
            end
        end
    end

    // Winner colour/mode are captured here so a later active-set copy cannot alter in-flight pixels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_pack  <= '0;
            r_s1_hit   <= '0;
            r_s1_color <= '0;
            r_s1_blend <= 1'b0;
            r_s2_pack  <= '0;
        end else begin
            r_s1_pack  <= i_pack;
            r_s1_hit   <= en ? w_hit : '0;
            r_s1_color <= w_win_color;
            r_s1_blend <= w_win_blend;
            r_s2_pack  <= r_s1_pack;
            if (|r_s1_hit) begin
                r_s2_pack[RGB_LSB +: 24] <= r_s1_blend
                    ? blend50(r_s1_pack[RGB_LSB +: 24], r_s1_color)
                    : r_s1_color;
            end
        end
    end

    assign o_pack = r_s2_pack;

endmodule
